div_arbiter: RTL
================

# div_arbiter

Round-robin arbiter and sequencer that shares one sign-magnitude 32-bit iterative divider (start/busy handshake, quotient `z`, remainder `r`) among `N_REQ` requesters. It accepts one request at a time over valid/ready and runs the divider's start/busy protocol. It returns each result, with the requester's tag, on a per-requester response channel. It sits between the lab CPU's execution units and the divider.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TAG_W`, default 4: width of the opaque tag that is returned with each result.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  one-hot grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- `req_x`, `req_y`  in  N_REQ*32 each  dividend and divisor, sign-magnitude; slice `i` is bits `[32i+31:32i]`.
- `req_tag`  in  N_REQ*TAG_W  per-requester tag.
- `rsp_valid`  out  N_REQ  one-hot response valid.
- `rsp_ready`  in  N_REQ  per-requester response ready.
- `rsp_z`, `rsp_r`  out  32 each  quotient and remainder, shared bus.
- `rsp_tag`  out  TAG_W  tag of the current response.
- `rsp_dz`  out  1  divide-by-zero flag.
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_x`, `div_y`  out  32 each  divider operands.
- `div_busy`  in  1  divider busy.
- `div_z`, `div_r`  in  32 each  divider results.

## Operation
- The FSM has five states: IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP.
- **IDLE**
  - The round-robin pick starts at `ptr` and selects the first `i` (ascending, wrapping) with `req_valid[i]`.
  - `req_ready[g]` is driven high combinationally for the granted requester only.
  - On that edge, latch x, y, tag and g, then go to ISSUE.
  - With no valid request, stay in IDLE.
- **ISSUE**: drive `div_start`=1 for exactly one cycle, then go to WAIT_HI.
- **WAIT_HI**: wait for `div_busy`=1, then go to WAIT_LO.
- **WAIT_LO**: when `div_busy`=0, capture `div_z`/`div_r` into the result registers, then go to RESP.
- **RESP**
  - `rsp_valid[g]`=1.
  - `rsp_z`, `rsp_r`, `rsp_tag` and `rsp_dz` are held stable until `rsp_ready[g]`.
  - On the handshake, `ptr` ← (g+1) mod N_REQ, then go to IDLE.
- `div_x`/`div_y` are driven from the operand registers in every state.
- `req_ready` is 0 outside IDLE, so only one division is in flight at a time.
- `rsp_ready` of non-granted requesters is ignored.
- Arithmetic is pass-through; the controller never modifies results.
  - Sign: quotient sign = x[31]^y[31]; remainder sign = x[31]; magnitudes use bits [30:0] only.
- `rst` at any point, including mid-division:
  - FSM returns to IDLE and `ptr`=0.
  - Any in-flight result is discarded.
  - The divider is reset by the same `rst`.

## Timing
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_z`=0, `rsp_r`=0, `rsp_tag`=0, `rsp_dz`=0.
  - `div_start`=0, `div_x`=0, `div_y`=0.
- Latency: if the accept is in cycle 0, `div_start` is high in cycle 1.
  - `rsp_valid` rises in cycle 3+B, where B is the number of cycles `div_busy` is high (B≥1).
- Throughput: the next grant comes at the earliest in the cycle after the response handshake.
- `div_start` is never asserted while `div_busy`=1.

## Configuration
- `DIV_ARB_DIVZERO_EN` defined:
  - If the latched y[30:0]==0, the FSM goes IDLE→RESP directly, without pulsing `div_start`.
  - Response: `rsp_z`={x[31]^y[31], 31'h7FFFFFFF}, `rsp_r`=x, `rsp_dz`=1.
  - The result is available 1 cycle after the accept.
- `DIV_ARB_DIVZERO_EN` undefined:
  - Divisor magnitude 0 is sent to the divider like any other value.
  - `rsp_dz` is tied to 0.

## Structure
- Package `div_arb_pkg` holds:
  - the state enum typedef (IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP);
  - the constants `DATA_W=32` and `SIGN_BIT=31`;
  - the div-zero saturation constant `31'h7FFFFFFF`.
- One sub-module, `rr_arbiter` (parameter N): inputs request vector and `ptr`; outputs one-hot grant and encoded index; combinational.

## Test plan
- **Single request:** requester 0 sends x=100, y=7, tag=3. Expect `div_start` for exactly 1 cycle, then `rsp_valid[0]` with z=14, r=2, tag=3.
- **Signed operands:** x=0x80000064, y=7. Expect z=0x8000000E, r=0x80000002.
- **Contention:** all 4 requesters valid continuously. Expect grants in order 0,1,2,3,0, with each response tag matching its requester.
- **Backpressure:** `rsp_ready[g]` held low for 5 cycles. Expect the response held stable, `req_ready` stays 0, and no `div_start`.
- **Divide by zero, macro on:** x=0x00000009, y=0x80000000. Expect z=0xFFFFFFFF, r=9, `rsp_dz`=1, and no `div_start`.
- **Reset mid-division:** assert `rst` during WAIT_LO. Expect all outputs at reset values, `ptr`=0, and the next grant going to the lowest valid requester.

Source files
------------

// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared types and constants for the divider arbiter.
package div_arb_pkg;

  localparam int DATA_W = 32;
  localparam int SIGN_BIT = 31;
  localparam logic [30:0] DZ_SAT = 31'h7FFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    RESP
  } state_t;

endpackage

// File: rtl/div_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting at ptr.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sequencer sharing one iterative divider.
// Optional DIV_ARB_DIVZERO_EN answers zero divisors without the divider.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TAG_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_x,
  input  logic [N_REQ*DATA_W-1:0]   req_y,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [DATA_W-1:0]         rsp_z,
  output logic [DATA_W-1:0]         rsp_r,
  output logic [TAG_W-1:0]          rsp_tag,
  output logic                      rsp_dz,
  output logic                      div_start,
  output logic [DATA_W-1:0]         div_x,
  output logic [DATA_W-1:0]         div_y,
  input  logic                      div_busy,
  input  logic [DATA_W-1:0]         div_z,
  input  logic [DATA_W-1:0]         div_r
);

  localparam int IW = $clog2(N_REQ);

  state_t state, nstate;

  logic [IW-1:0]     ptr, g, pick;
  logic [N_REQ-1:0]  gnt;
  logic [DATA_W-1:0] x_q, y_q, z_q, r_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] sel_x, sel_y;
  logic [TAG_W-1:0]  sel_tag;
  logic              acc;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (pick)
  );

  assign sel_x   = req_x[int'(pick)*DATA_W +: DATA_W];
  assign sel_y   = req_y[int'(pick)*DATA_W +: DATA_W];
  assign sel_tag = req_tag[int'(pick)*TAG_W +: TAG_W];

`ifdef DIV_ARB_DIVZERO_EN
  logic dz_hit, dz_q;
  assign dz_hit = ~|sel_y[SIGN_BIT-1:0];
  assign rsp_dz = dz_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dz_q <= 1'b0;
    else if (acc) dz_q <= dz_hit;
  end
`else
  assign rsp_dz = 1'b0;
`endif

  always_comb begin
    nstate    = state;
    div_start = 1'b0;
    acc       = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          acc    = 1'b1;
          nstate = ISSUE;
`ifdef DIV_ARB_DIVZERO_EN
          if (dz_hit) nstate = RESP;
`endif
        end
      end
      ISSUE: begin
        div_start = 1'b1;
        nstate    = WAIT_HI;
      end
      WAIT_HI: if (div_busy) nstate = WAIT_LO;
      WAIT_LO: if (!div_busy) nstate = RESP;
      RESP:    if (rsp_ready[g]) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      g     <= '0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      r_q   <= '0;
      tag_q <= '0;
    end else begin
      state <= nstate;
      if (acc) begin
        g     <= pick;
        x_q   <= sel_x;
        y_q   <= sel_y;
        tag_q <= sel_tag;
`ifdef DIV_ARB_DIVZERO_EN
        if (dz_hit) begin
          z_q <= {sel_x[SIGN_BIT] ^ sel_y[SIGN_BIT], DZ_SAT};
          r_q <= sel_x;
        end
`endif
      end
      if (state == WAIT_LO && !div_busy) begin
        z_q <= div_z;
        r_q <= div_r;
      end
      if (state == RESP && rsp_ready[g])
        ptr <= (g == IW'(N_REQ - 1)) ? '0 : g + 1'b1;
    end
  end

  // Reset must also mask the combinational grant.
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign rsp_valid = (state == RESP) ? (N_REQ'(1) << g) : '0;
  assign rsp_z     = z_q;
  assign rsp_r     = r_q;
  assign rsp_tag   = tag_q;
  assign div_x     = x_q;
  assign div_y     = y_q;

endmodule
